// File: rtl/cgra_cfg_arbiter.sv
// Round-robin arbiter sharing one PRR's CGRA configuration port among NUM_REQ requesters.
// Writes are posted for one cycle; a read holds the port until its response pulse.
module cgra_cfg_arbiter #(
  parameter int NUM_REQ             = 4,
  parameter int CGRA_CFG_ADDR_WIDTH = 32,
  parameter int CGRA_CFG_DATA_WIDTH = 32,
  parameter int RD_LATENCY          = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ-1:0]                     req_wr,
  input  logic [NUM_REQ*CGRA_CFG_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*CGRA_CFG_DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  output logic [CGRA_CFG_DATA_WIDTH-1:0]         rsp_data,
  output logic                                   cfg_wr_en,
  output logic [CGRA_CFG_ADDR_WIDTH-1:0]         cfg_wr_addr,
  output logic [CGRA_CFG_DATA_WIDTH-1:0]         cfg_wr_data,
  output logic                                   cfg_rd_en,
  output logic [CGRA_CFG_ADDR_WIDTH-1:0]         cfg_rd_addr,
  input  logic [CGRA_CFG_DATA_WIDTH-1:0]         cfg_rd_data,
  output logic                                   busy
);

  localparam int AW    = CGRA_CFG_ADDR_WIDTH;
  localparam int DW    = CGRA_CFG_DATA_WIDTH;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [CNT_W-1:0]   rd_cnt;

  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IDX_W-1:0]   next_ptr;
  logic               accept;
  logic               sel_wr;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;
  int                 cand;

  // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ; first valid one wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    grant_oh  = '0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(grant_idx) == i) begin
        grant_oh[i] = grant_found;
        sel_wr      = req_wr[i];
        sel_addr    = req_addr[i*AW +: AW];
        sel_wdata   = req_wdata[i*DW +: DW];
      end
    end
  end

  // Reset gates the grant so nothing is offered while the state registers are being cleared.
  assign req_ready = (!reset && state == IDLE) ? grant_oh : '0;
  assign accept    = |req_ready;
  assign next_ptr  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
  assign busy      = (state != IDLE) || cfg_wr_en;

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      rd_cnt      <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      cfg_wr_en   <= 1'b0;
      cfg_wr_addr <= '0;
      cfg_wr_data <= '0;
      cfg_rd_en   <= 1'b0;
      cfg_rd_addr <= '0;
    end else begin
      cfg_wr_en <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            rr_ptr <= next_ptr;
            if (sel_wr) begin
              cfg_wr_en   <= 1'b1;
              cfg_wr_addr <= sel_addr;
              cfg_wr_data <= sel_wdata;
            end else begin
              owner       <= grant_idx;
              cfg_rd_en   <= 1'b1;
              cfg_rd_addr <= sel_addr;
              rd_cnt      <= CNT_W'(1);
              state       <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // The last enable cycle samples the read data; the response follows one cycle later.
          if (rd_cnt == CNT_W'(RD_LATENCY)) begin
            cfg_rd_en        <= 1'b0;
            rsp_valid[owner] <= 1'b1;
            rsp_data         <= cfg_rd_data;
            rd_cnt           <= '0;
            state            <= IDLE;
          end else begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_wr_rd_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(cfg_wr_en && cfg_rd_en));
  a_rsp_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(rsp_valid));

endmodule

// File: tb/tb_cgra_cfg_arbiter.sv
// Bench for cgra_cfg_arbiter: three instances (RD_LATENCY 1..3) share stimulus; directed
// table/sequence tests plus randomized traffic against a cycle-timeline reference model.
module tb_cgra_cfg_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NI  = 3;
  localparam int RCY = 600;
  localparam int AMX = RCY + 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_wr;
  logic [AW-1:0] addr_v  [N];
  logic [DW-1:0] wdata_v [N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] cfg_rd_data;

  logic [N-1:0]  ready_o     [NI];
  logic [N-1:0]  rsp_valid_o [NI];
  logic [DW-1:0] rsp_data_o  [NI];
  logic          wr_en_o     [NI];
  logic [AW-1:0] wr_addr_o   [NI];
  logic [DW-1:0] wr_data_o   [NI];
  logic          rd_en_o     [NI];
  logic [AW-1:0] rd_addr_o   [NI];
  logic          busy_o      [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = addr_v[i];
      req_wdata[i*DW +: DW] = wdata_v[i];
    end
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cgra_cfg_arbiter #(
      .NUM_REQ(N), .CGRA_CFG_ADDR_WIDTH(AW), .CGRA_CFG_DATA_WIDTH(DW), .RD_LATENCY(g + 1)
    ) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(ready_o[g]), .rsp_valid(rsp_valid_o[g]), .rsp_data(rsp_data_o[g]),
      .cfg_wr_en(wr_en_o[g]), .cfg_wr_addr(wr_addr_o[g]), .cfg_wr_data(wr_data_o[g]),
      .cfg_rd_en(rd_en_o[g]), .cfg_rd_addr(rd_addr_o[g]), .cfg_rd_data(cfg_rd_data),
      .busy(busy_o[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid   = '0;
    req_wr      = '0;
    cfg_rd_data = '0;
    for (int i = 0; i < N; i++) begin
      addr_v[i]  = '0;
      wdata_v[i] = '0;
    end
  endtask

  // Leaves the bench one step past the first post-reset edge: cycle 0 of the next test.
  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  wr;
    logic [31:0] rd_data;
    logic [3:0]  exp_ready;
    logic        exp_wr_en;
    logic [31:0] exp_wr_addr;
    logic        exp_rd_en;
    logic [3:0]  exp_rsp;
    logic [31:0] exp_rsp_data;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [11];

  // Reference-model timeline for the random phase, indexed by cycle number.
  logic          exp_wr  [AMX];
  logic [AW-1:0] exp_wa  [AMX];
  logic [DW-1:0] exp_wd  [AMX];
  logic          exp_rd  [AMX];
  logic [AW-1:0] exp_ra  [AMX];
  logic [N-1:0]  exp_rsp [AMX];
  int            exp_src [AMX];
  logic [DW-1:0] hist    [AMX];

  task automatic run_random(input int k);
    int lat;
    int rr;
    int free_cyc;
    int w;
    int idx;
    logic [N-1:0]  exp_rdy;
    logic [AW-1:0] last_wa;
    logic [DW-1:0] last_wd;
    logic [DW-1:0] last_rsp;
    lat = k + 1;
    rr = 0;
    free_cyc = 0;
    last_wa = '0;
    last_wd = '0;
    last_rsp = '0;
    for (int c = 0; c < AMX; c++) begin
      exp_wr[c] = 1'b0; exp_wa[c] = '0; exp_wd[c] = '0;
      exp_rd[c] = 1'b0; exp_ra[c] = '0; exp_rsp[c] = '0; exp_src[c] = 0; hist[c] = '0;
    end
    do_reset();
    for (int c = 0; c < RCY; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(1) == 1) begin
          req_valid[i] = 1'b1;
          req_wr[i]    = ($urandom_range(2) != 0);
          addr_v[i]    = $urandom;
          wdata_v[i]   = $urandom;
        end
      end
      cfg_rd_data = $urandom;
      hist[c] = cfg_rd_data;
      #1;
      exp_rdy = '0;
      w = -1;
      if (c >= free_cyc) begin
        for (int j = 0; j < N; j++) begin
          idx = (rr + j) % N;
          if (w < 0 && req_valid[idx]) w = idx;
        end
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
      if (exp_wr[c]) begin
        last_wa = exp_wa[c];
        last_wd = exp_wd[c];
      end
      if (exp_rsp[c] != '0) last_rsp = hist[exp_src[c]];
      check("rand_ready", 32'(ready_o[k]), 32'(exp_rdy));
      check("rand_wr_en", 32'(wr_en_o[k]), 32'(exp_wr[c]));
      check("rand_wr_addr", wr_addr_o[k], last_wa);
      check("rand_wr_data", wr_data_o[k], last_wd);
      check("rand_rd_en", 32'(rd_en_o[k]), 32'(exp_rd[c]));
      if (exp_rd[c]) check("rand_rd_addr", rd_addr_o[k], exp_ra[c]);
      check("rand_rsp_valid", 32'(rsp_valid_o[k]), 32'(exp_rsp[c]));
      check("rand_rsp_data", rsp_data_o[k], last_rsp);
      check("rand_busy", 32'(busy_o[k]), 32'(exp_wr[c] | exp_rd[c]));
      if (w >= 0) begin
        rr = (w + 1) % N;
        if (req_wr[w]) begin
          exp_wr[c+1] = 1'b1;
          exp_wa[c+1] = addr_v[w];
          exp_wd[c+1] = wdata_v[w];
        end else begin
          for (int j = 1; j <= lat; j++) begin
            exp_rd[c+j] = 1'b1;
            exp_ra[c+j] = addr_v[w];
          end
          exp_rsp[c+lat+1] = N'(1) << w;
          exp_src[c+lat+1] = c + lat;
          free_cyc = c + lat + 1;
        end
      end
      tick();
      if (w >= 0) req_valid[w] = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt [N];

    vecs[0]  = '{4'b1111, 4'b1111, 32'h0,    4'b0001, 1'b0, 32'h0,   1'b0, 4'b0000, 32'h0,    1'b0};
    vecs[1]  = '{4'b1111, 4'b1111, 32'h0,    4'b0010, 1'b1, 32'h100, 1'b0, 4'b0000, 32'h0,    1'b1};
    vecs[2]  = '{4'b1111, 4'b1111, 32'h0,    4'b0100, 1'b1, 32'h101, 1'b0, 4'b0000, 32'h0,    1'b1};
    vecs[3]  = '{4'b1111, 4'b1111, 32'h0,    4'b1000, 1'b1, 32'h102, 1'b0, 4'b0000, 32'h0,    1'b1};
    vecs[4]  = '{4'b1111, 4'b1111, 32'h0,    4'b0001, 1'b1, 32'h103, 1'b0, 4'b0000, 32'h0,    1'b1};
    vecs[5]  = '{4'b0011, 4'b0010, 32'h0,    4'b0010, 1'b1, 32'h100, 1'b0, 4'b0000, 32'h0,    1'b1};
    vecs[6]  = '{4'b0001, 4'b0000, 32'h1111, 4'b0001, 1'b1, 32'h101, 1'b0, 4'b0000, 32'h0,    1'b1};
    vecs[7]  = '{4'b1000, 4'b1000, 32'h5555, 4'b0000, 1'b0, 32'h101, 1'b1, 4'b0000, 32'h0,    1'b1};
    vecs[8]  = '{4'b1000, 4'b1000, 32'h7777, 4'b1000, 1'b0, 32'h101, 1'b0, 4'b0001, 32'h5555, 1'b0};
    vecs[9]  = '{4'b0000, 4'b0000, 32'h0,    4'b0000, 1'b1, 32'h103, 1'b0, 4'b0000, 32'h5555, 1'b1};
    vecs[10] = '{4'b0000, 4'b0000, 32'h0,    4'b0000, 1'b0, 32'h103, 1'b0, 4'b0000, 32'h5555, 1'b0};

    // T1: reset held with every requester asking.
    clear_inputs();
    reset = 1'b1;
    req_valid = '1;
    req_wr = '1;
    repeat (3) begin
      @(posedge clk);
      #2;
      for (int g = 0; g < NI; g++) begin
        check("t1_ready", 32'(ready_o[g]), 32'h0);
        check("t1_wr_en", 32'(wr_en_o[g]), 32'h0);
        check("t1_rd_en", 32'(rd_en_o[g]), 32'h0);
        check("t1_rsp_valid", 32'(rsp_valid_o[g]), 32'h0);
        check("t1_busy", 32'(busy_o[g]), 32'h0);
      end
    end

    // T2: single write from requester 2.
    do_reset();
    req_valid = 4'b0100; req_wr = 4'b0100;
    addr_v[2] = 32'h0000_0005; wdata_v[2] = 32'hDEAD_BEEF;
    #1;
    check("t2_ready", 32'(ready_o[0]), 32'h4);
    tick();
    req_valid = '0;
    #1;
    check("t2_wr_en_c1", 32'(wr_en_o[0]), 32'h1);
    check("t2_wr_addr", wr_addr_o[0], 32'h5);
    check("t2_wr_data", wr_data_o[0], 32'hDEAD_BEEF);
    tick();
    #1;
    check("t2_wr_en_c2", 32'(wr_en_o[0]), 32'h0);
    check("t2_wr_addr_hold", wr_addr_o[0], 32'h5);

    // T3: continuous writes from all four requesters.
    do_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    req_valid = '1; req_wr = '1;
    for (int c = 0; c < 16; c++) begin
      #1;
      for (int i = 0; i < N; i++) if (ready_o[0][i]) cnt[i]++;
      check("t3_order", 32'(ready_o[0]), 32'h1 << (c % N));
      if (c > 0) check("t3_wr_en", 32'(wr_en_o[0]), 32'h1);
      tick();
    end
    req_valid = '0;
    for (int i = 0; i < N; i++) check("t3_share", cnt[i], 4);

    // Table-driven vectors on the RD_LATENCY=1 instance.
    do_reset();
    for (int i = 0; i < N; i++) begin
      addr_v[i]  = 32'h100 + 32'(i);
      wdata_v[i] = 32'hA000_0000 + 32'(i);
    end
    foreach (vecs[r]) begin
      req_valid   = vecs[r].valid;
      req_wr      = vecs[r].wr;
      cfg_rd_data = vecs[r].rd_data;
      #1;
      check($sformatf("vec%0d_ready", r), 32'(ready_o[0]), 32'(vecs[r].exp_ready));
      check($sformatf("vec%0d_wr_en", r), 32'(wr_en_o[0]), 32'(vecs[r].exp_wr_en));
      check($sformatf("vec%0d_wr_addr", r), wr_addr_o[0], vecs[r].exp_wr_addr);
      check($sformatf("vec%0d_rd_en", r), 32'(rd_en_o[0]), 32'(vecs[r].exp_rd_en));
      check($sformatf("vec%0d_rsp", r), 32'(rsp_valid_o[0]), 32'(vecs[r].exp_rsp));
      check($sformatf("vec%0d_rsp_data", r), rsp_data_o[0], vecs[r].exp_rsp_data);
      check($sformatf("vec%0d_busy", r), 32'(busy_o[0]), 32'(vecs[r].exp_busy));
      tick();
    end

    // T4: RD_LATENCY=2 read from requester 1 with requester 0 waiting.
    do_reset();
    cfg_rd_data = 32'h0000_1234;
    req_valid = 4'b0010; req_wr = 4'b0000; addr_v[1] = 32'h40;
    #1;
    check("t4_ready_c0", 32'(ready_o[1]), 32'h2);
    tick();
    req_valid = 4'b0001; req_wr = 4'b0001; addr_v[0] = 32'h77;
    #1;
    check("t4_rd_en_c1", 32'(rd_en_o[1]), 32'h1);
    check("t4_rd_addr", rd_addr_o[1], 32'h40);
    check("t4_ready_c1", 32'(ready_o[1]), 32'h0);
    tick();
    #1;
    check("t4_rd_en_c2", 32'(rd_en_o[1]), 32'h1);
    check("t4_ready_c2", 32'(ready_o[1]), 32'h0);
    check("t4_rsp_c2", 32'(rsp_valid_o[1]), 32'h0);
    tick();
    #1;
    check("t4_rsp_c3", 32'(rsp_valid_o[1]), 32'h2);
    check("t4_rsp_data", rsp_data_o[1], 32'h1234);
    check("t4_rd_en_c3", 32'(rd_en_o[1]), 32'h0);
    check("t4_ready_c3", 32'(ready_o[1]), 32'h1);
    tick();
    req_valid = '0;
    #1;
    check("t4_rsp_c4", 32'(rsp_valid_o[1]), 32'h0);
    check("t4_rsp_data_hold", rsp_data_o[1], 32'h1234);
    check("t4_wr_en_c4", 32'(wr_en_o[1]), 32'h1);

    // T5: RD_LATENCY=1 read from requester 0 with requester 3 write pending.
    do_reset();
    req_valid = 4'b1001; req_wr = 4'b1000;
    addr_v[0] = 32'h80; addr_v[3] = 32'h33; wdata_v[3] = 32'h3333;
    #1;
    check("t5_ready_c0", 32'(ready_o[0]), 32'h1);
    tick();
    req_valid = 4'b1000;
    cfg_rd_data = 32'hCAFE;
    #1;
    check("t5_ready_c1", 32'(ready_o[0]), 32'h0);
    check("t5_rd_en_c1", 32'(rd_en_o[0]), 32'h1);
    check("t5_rd_addr", rd_addr_o[0], 32'h80);
    tick();
    cfg_rd_data = 32'hBAD0;
    #1;
    check("t5_rsp_c2", 32'(rsp_valid_o[0]), 32'h1);
    check("t5_rsp_data", rsp_data_o[0], 32'hCAFE);
    check("t5_ready_c2", 32'(ready_o[0]), 32'h8);
    tick();
    req_valid = '0;
    #1;
    check("t5_wr_en_c3", 32'(wr_en_o[0]), 32'h1);
    check("t5_wr_addr", wr_addr_o[0], 32'h33);
    check("t5_wr_data", wr_data_o[0], 32'h3333);
    check("t5_rd_en_c3", 32'(rd_en_o[0]), 32'h0);

    // T6: reset in cycle 1 of an RD_LATENCY=3 read.
    do_reset();
    req_valid = 4'b0001; req_wr = 4'b0000; addr_v[0] = 32'h90;
    #1;
    check("t6_ready_c0", 32'(ready_o[2]), 32'h1);
    tick();
    req_valid = '0;
    reset = 1'b1;
    #1;
    check("t6_rd_en_c1", 32'(rd_en_o[2]), 32'h1);
    tick();
    reset = 1'b0;
    req_valid = 4'b0110; req_wr = 4'b0110;
    addr_v[1] = 32'h11; addr_v[2] = 32'h22;
    #1;
    check("t6_rd_en_c2", 32'(rd_en_o[2]), 32'h0);
    check("t6_ready_c2", 32'(ready_o[2]), 32'h2);
    tick();
    req_valid = 4'b0100;
    #1;
    check("t6_wr_addr_c3", wr_addr_o[2], 32'h11);
    check("t6_ready_c3", 32'(ready_o[2]), 32'h4);
    tick();
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t6_no_rsp", 32'(rsp_valid_o[2]), 32'h0);
      check("t6_no_rd_en", 32'(rd_en_o[2]), 32'h0);
      tick();
    end

    // Randomized traffic, one latency at a time.
    for (int k = 0; k < NI; k++) run_random(k);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
